// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Access-size encoding, FSM states and the base byte-lane masks.
package dmem_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10,
    MEM_RSVD = 2'b11
  } mem_type_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;

  // Unshifted lane masks; byte and half are shifted left by the byte offset.
  localparam logic [3:0] LANE_BYTE = 4'b0001;
  localparam logic [3:0] LANE_HALF = 4'b0011;
  localparam logic [3:0] LANE_WORD = 4'b1111;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response handshake bundle between the core's load/store port and the responder.
interface dmem_responder_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req_we;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [1:0]            req_type;
  logic                  req_sign;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_addr, req_we, req_wdata, req_type, req_sign, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_wdata, req_type, req_sign, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_lane_align.sv
// Little-endian lane handling: store byte enables, replicated write data, misalignment
// detection, and load-side byte/half extraction with sign or zero extension.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  off,
  input  mem_type_t   mem_type,
  input  logic        sign,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic        err,
  output logic [31:0] rdata_ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    unique case (off)
      2'd0: byte_sel = rword[7:0];
      2'd1: byte_sel = rword[15:8];
      2'd2: byte_sel = rword[23:16];
      2'd3: byte_sel = rword[31:24];
    endcase
    // Only offsets 0 and 2 are legal for halves; off[0] is flagged as an error.
    half_sel = off[1] ? rword[31:16] : rword[15:0];
  end

  always_comb begin
    be        = '0;
    wdata_rep = '0;
    err       = 1'b0;
    rdata_ext = '0;
    unique case (mem_type)
      MEM_BYTE: begin
        be        = LANE_BYTE << off;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{sign & byte_sel[7]}}, byte_sel};
      end
      MEM_HALF: begin
        err       = off[0];
        be        = LANE_HALF << off;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{16{sign & half_sel[15]}}, half_sel};
      end
      MEM_WORD: begin
        err       = (off != 2'd0);
        be        = LANE_WORD;
        wdata_rep = wdata;
        rdata_ext = rword;
      end
      MEM_RSVD: begin
        err = 1'b1;
      end
    endcase
    if (err) be = '0;
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: single-outstanding valid/ready front end with configurable
// wait states over a word-organised RAM. Stores commit and loads sample at accept.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic             clk_i,
  input  logic             rst_n,
  dmem_responder_if.slave  bus
);

  // Counter runs WAIT_CYCLES-1 .. 0 so WAIT lasts exactly WAIT_CYCLES cycles.
  localparam logic [3:0] WaitLoad = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  state_t                  state_q;
  logic [3:0]              cnt_q;
  logic                    rsp_valid_q;
  logic                    rsp_err_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;

  logic [DATA_WIDTH-1:0]   ram [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0]   widx;
  logic [1:0]              off;
  logic                    accept;
  logic [3:0]              be;
  logic [31:0]             wdata_rep;
  logic                    err;
  logic [31:0]             rdata_ext;
  logic                    unused_addr;

  assign widx        = bus.req_addr[DEPTH_LOG2+1:2];
  assign off         = bus.req_addr[1:0];
  assign unused_addr = ^bus.req_addr[ADDR_WIDTH-1:DEPTH_LOG2+2];
  assign accept      = (state_q == IDLE) && bus.req_valid;

  dmem_lane_align u_lane_align (
    .off       (off),
    .mem_type  (mem_type_t'(bus.req_type)),
    .sign      (bus.req_sign),
    .wdata     (bus.req_wdata),
    .rword     (ram[widx]),
    .be        (be),
    .wdata_rep (wdata_rep),
    .err       (err),
    .rdata_ext (rdata_ext)
  );

  always_ff @(posedge clk_i) begin
    if (accept && bus.req_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) ram[widx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            rsp_err_q   <= err;
            rsp_rdata_q <= (err || bus.req_we) ? '0 : rdata_ext;
            if (WAIT_CYCLES == 0) begin
              state_q <= RESP;
            end else begin
              state_q <= WAIT;
              cnt_q   <= WaitLoad;
            end
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) state_q <= RESP;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        RESP: begin
          // Valid rises one cycle after entering RESP and drops on the handshake edge.
          if (rsp_valid_q && bus.rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
          end else begin
            rsp_valid_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a zero-wait instance and a three-wait instance
// exercised with hand-computed load/store vectors.
module tb_dmem_responder;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  dmem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if0 ();
  dmem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if3 ();

  dmem_responder #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_LOG2(10), .WAIT_CYCLES(0)
  ) dut0 (
    .clk_i (clk),
    .rst_n (rst_n),
    .bus   (if0)
  );

  dmem_responder #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_LOG2(10), .WAIT_CYCLES(3)
  ) dut3 (
    .clk_i (clk),
    .rst_n (rst_n),
    .bus   (if3)
  );

  // Called just after a rising edge with dut0 idle; rsp_ready on dut0 is held high.
  task automatic xact0(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                       input logic [1:0] typ, input logic sign,
                       output logic [31:0] rdata, output logic err, output int lat);
    if0.req_addr  = addr;
    if0.req_we    = we;
    if0.req_wdata = wdata;
    if0.req_type  = typ;
    if0.req_sign  = sign;
    if0.req_valid = 1'b1;
    @(posedge clk); #1;
    if0.req_valid = 1'b0;
    lat = 0;
    while (!if0.rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rdata = if0.rsp_rdata;
    err   = if0.rsp_err;
    @(posedge clk); #1;
  endtask

  task automatic xact3(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                       input logic [1:0] typ, input logic sign, input int hold,
                       output logic [31:0] rdata, output logic err, output int lat,
                       output bit stable, output bit ready_low, output bit ready_back);
    if3.req_addr  = addr;
    if3.req_we    = we;
    if3.req_wdata = wdata;
    if3.req_type  = typ;
    if3.req_sign  = sign;
    if3.rsp_ready = 1'b0;
    if3.req_valid = 1'b1;
    @(posedge clk); #1;
    if3.req_valid = 1'b0;
    lat = 0;
    ready_low = 1'b1;
    while (!if3.rsp_valid && lat < 20) begin
      if (if3.req_ready) ready_low = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    rdata  = if3.rsp_rdata;
    err    = if3.rsp_err;
    stable = 1'b1;
    repeat (hold) begin
      if (if3.req_ready) ready_low = 1'b0;
      @(posedge clk); #1;
      if (!if3.rsp_valid || if3.rsp_rdata !== rdata || if3.rsp_err !== err) stable = 1'b0;
    end
    if (if3.req_ready) ready_low = 1'b0;
    if3.rsp_ready = 1'b1;
    @(posedge clk); #1;
    if3.rsp_ready = 1'b0;
    ready_back = if3.req_ready && !if3.rsp_valid;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (if0.req_ready !== 1'b1)
      $display("FAIL reset_ready0: got %b expected 1", if0.req_ready); else passes++;
    checks++; if ({if0.rsp_valid, if0.rsp_err, if0.rsp_rdata} !== 34'h0)
      $display("FAIL reset_rsp0: got v=%b e=%b d=%h expected all 0",
               if0.rsp_valid, if0.rsp_err, if0.rsp_rdata); else passes++;
    checks++; if (if3.req_ready !== 1'b1)
      $display("FAIL reset_ready3: got %b expected 1", if3.req_ready); else passes++;
    checks++; if ({if3.rsp_valid, if3.rsp_err, if3.rsp_rdata} !== 34'h0)
      $display("FAIL reset_rsp3: got v=%b e=%b d=%h expected all 0",
               if3.rsp_valid, if3.rsp_err, if3.rsp_rdata); else passes++;
  endtask

  task automatic test_word();
    logic [31:0] d; logic e; int lat;
    xact0(32'h10, 1'b1, 32'hDEADBEEF, MEM_WORD, 1'b0, d, e, lat);
    checks++; if (lat !== 1 || e !== 1'b0 || d !== 32'h0)
      $display("FAIL store_word: got lat=%0d e=%b d=%h expected lat=1 e=0 d=0", lat, e, d);
    else passes++;
    xact0(32'h10, 1'b0, 32'h0, MEM_WORD, 1'b0, d, e, lat);
    checks++; if (lat !== 1)
      $display("FAIL load_word_lat: got %0d expected 1", lat); else passes++;
    checks++; if (d !== 32'hDEADBEEF || e !== 1'b0)
      $display("FAIL load_word: got d=%h e=%b expected DEADBEEF e=0", d, e); else passes++;
  endtask

  task automatic test_byte();
    logic [31:0] d; logic e; int lat;
    xact0(32'h10, 1'b1, 32'h0, MEM_WORD, 1'b0, d, e, lat);
    xact0(32'h13, 1'b1, 32'h12345680, MEM_BYTE, 1'b0, d, e, lat);
    checks++; if (e !== 1'b0) $display("FAIL store_byte_err: got %b expected 0", e);
    else passes++;
    xact0(32'h13, 1'b0, 32'h0, MEM_BYTE, 1'b1, d, e, lat);
    checks++; if (d !== 32'hFFFFFF80 || e !== 1'b0)
      $display("FAIL load_byte_sx: got d=%h e=%b expected FFFFFF80 e=0", d, e); else passes++;
    xact0(32'h13, 1'b0, 32'h0, MEM_BYTE, 1'b0, d, e, lat);
    checks++; if (d !== 32'h00000080)
      $display("FAIL load_byte_zx: got %h expected 00000080", d); else passes++;
    xact0(32'h10, 1'b0, 32'h0, MEM_WORD, 1'b0, d, e, lat);
    checks++; if (d !== 32'h80000000)
      $display("FAIL byte_lane_word: got %h expected 80000000", d); else passes++;
    xact0(32'h12, 1'b0, 32'h0, MEM_BYTE, 1'b1, d, e, lat);
    checks++; if (d !== 32'h0)
      $display("FAIL load_byte_lane2: got %h expected 00000000", d); else passes++;
  endtask

  task automatic test_half_and_errors();
    logic [31:0] d; logic e; int lat;
    xact0(32'h20, 1'b1, 32'h0, MEM_WORD, 1'b0, d, e, lat);
    xact0(32'h22, 1'b1, 32'hABCD1234, MEM_HALF, 1'b0, d, e, lat);
    xact0(32'h22, 1'b0, 32'h0, MEM_HALF, 1'b0, d, e, lat);
    checks++; if (d !== 32'h00001234 || e !== 1'b0)
      $display("FAIL load_half: got d=%h e=%b expected 00001234 e=0", d, e); else passes++;
    xact0(32'h21, 1'b0, 32'h0, MEM_HALF, 1'b0, d, e, lat);
    checks++; if (e !== 1'b1 || d !== 32'h0 || lat !== 1)
      $display("FAIL half_misalign: got e=%b d=%h lat=%0d expected e=1 d=0 lat=1", e, d, lat);
    else passes++;
    xact0(32'h21, 1'b1, 32'h5678, MEM_HALF, 1'b0, d, e, lat);
    xact0(32'h22, 1'b1, 32'hFFFFFFFF, MEM_WORD, 1'b0, d, e, lat);
    checks++; if (e !== 1'b1)
      $display("FAIL word_misalign: got e=%b expected 1", e); else passes++;
    xact0(32'h20, 1'b0, 32'h0, MEM_WORD, 1'b0, d, e, lat);
    checks++; if (d !== 32'h12340000)
      $display("FAIL no_write_on_err: got %h expected 12340000", d); else passes++;
    xact0(32'h20, 1'b1, 32'h00008001, MEM_HALF, 1'b0, d, e, lat);
    xact0(32'h20, 1'b0, 32'h0, MEM_HALF, 1'b1, d, e, lat);
    checks++; if (d !== 32'hFFFF8001)
      $display("FAIL load_half_sx: got %h expected FFFF8001", d); else passes++;
    xact0(32'h10, 1'b0, 32'h0, MEM_RSVD, 1'b0, d, e, lat);
    checks++; if (e !== 1'b1 || d !== 32'h0)
      $display("FAIL rsvd_type: got e=%b d=%h expected e=1 d=0", e, d); else passes++;
  endtask

  task automatic test_alias();
    logic [31:0] d; logic e; int lat;
    xact0((32'd4 << 10) + 32'h8, 1'b1, 32'h11111111, MEM_WORD, 1'b0, d, e, lat);
    xact0(32'h8, 1'b0, 32'h0, MEM_WORD, 1'b0, d, e, lat);
    checks++; if (d !== 32'h11111111)
      $display("FAIL alias: got %h expected 11111111", d); else passes++;
  endtask

  task automatic test_wait_stall();
    logic [31:0] d; logic e; int lat; bit st, rl, rb;
    xact3(32'h4, 1'b1, 32'hCAFEF00D, MEM_WORD, 1'b0, 0, d, e, lat, st, rl, rb);
    checks++; if (lat !== 4 || e !== 1'b0)
      $display("FAIL wait_store: got lat=%0d e=%b expected lat=4 e=0", lat, e); else passes++;
    xact3(32'h4, 1'b0, 32'h0, MEM_WORD, 1'b0, 5, d, e, lat, st, rl, rb);
    checks++; if (lat !== 4)
      $display("FAIL wait_lat: got %0d expected 4", lat); else passes++;
    checks++; if (d !== 32'hCAFEF00D)
      $display("FAIL wait_data: got %h expected CAFEF00D", d); else passes++;
    checks++; if (st !== 1'b1)
      $display("FAIL stall_stable: got %b expected 1", st); else passes++;
    checks++; if (rl !== 1'b1)
      $display("FAIL busy_ready_low: got %b expected 1", rl); else passes++;
    checks++; if (rb !== 1'b1)
      $display("FAIL ready_after_hs: got %b expected 1", rb); else passes++;
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] d; logic e; int lat; bit st, rl, rb;
    // Load accepted, then reset while waiting: registered payload must clear at once.
    if3.req_addr = 32'h4; if3.req_we = 1'b0; if3.req_type = MEM_WORD; if3.req_sign = 1'b0;
    if3.req_valid = 1'b1;
    @(posedge clk); #1; if3.req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    checks++; if ({if3.rsp_valid, if3.rsp_err, if3.rsp_rdata} !== 34'h0 || if3.req_ready !== 1'b1)
      $display("FAIL async_reset_load: got v=%b e=%b d=%h rdy=%b expected 0 0 0 1",
               if3.rsp_valid, if3.rsp_err, if3.rsp_rdata, if3.req_ready); else passes++;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    if3.req_addr = 32'h40; if3.req_we = 1'b1; if3.req_wdata = 32'hA5A5A5A5;
    if3.req_valid = 1'b1;
    @(posedge clk); #1; if3.req_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (if3.req_ready !== 1'b0)
      $display("FAIL in_wait_ready: got %b expected 0", if3.req_ready); else passes++;
    rst_n = 1'b0; #1;
    checks++; if (if3.req_ready !== 1'b1 || if3.rsp_valid !== 1'b0)
      $display("FAIL async_reset_store: got rdy=%b v=%b expected 1 0",
               if3.req_ready, if3.rsp_valid); else passes++;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    xact3(32'h40, 1'b0, 32'h0, MEM_WORD, 1'b0, 0, d, e, lat, st, rl, rb);
    checks++; if (d !== 32'hA5A5A5A5 || e !== 1'b0 || lat !== 4)
      $display("FAIL store_survives_reset: got d=%h e=%b lat=%0d expected A5A5A5A5 0 4",
               d, e, lat); else passes++;
  endtask

  initial begin
    if0.req_valid = 1'b0; if0.req_addr = '0; if0.req_we = 1'b0; if0.req_wdata = '0;
    if0.req_type = 2'b00; if0.req_sign = 1'b0; if0.rsp_ready = 1'b1;
    if3.req_valid = 1'b0; if3.req_addr = '0; if3.req_we = 1'b0; if3.req_wdata = '0;
    if3.req_type = 2'b00; if3.req_sign = 1'b0; if3.rsp_ready = 1'b0;
    test_reset();
    test_word();
    test_byte();
    test_half_and_errors();
    test_alias();
    test_wait_stall();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
